// File: rtl/mem_arb_defs_pkg.sv
// rtl/mem_arb_defs_pkg.sv - state encodings, requester indices and default widths for mem_arbiter
package mem_arb_defs_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    VERIFY = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 3;

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - combinational 2-way round-robin picker
module mem_arb_rr
  import mem_arb_defs_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt,
  output logic       gnt_valid
);

  always_comb begin
    gnt_valid = |req;
    gnt       = REQ_A;
    case (req)
      2'b10:   gnt = REQ_B;
      // On contention the requester that did not win last time goes next.
      2'b11:   gnt = (last_grant == REQ_A) ? REQ_B : REQ_A;
      default: gnt = REQ_A;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter/sequencer for the 8x8 mem_system
// Optional write read-back check enabled by MEM_ARB_VERIFY_EN.
module mem_arbiter
  import mem_arb_defs_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_adr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_adr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          mem_op,
  output logic          mem_select,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_i,
  input  logic [DW-1:0] mem_o,
  output logic          busy,
  output logic          err
);

`ifdef MEM_ARB_VERIFY_EN
  localparam bit VERIFY_EN = 1'b1;
`else
  localparam bit VERIFY_EN = 1'b0;
`endif

  state_t state, state_next;
  logic   last_grant, gnt, gnt_valid;
  logic   gnt_q, we_q;
  logic   sel_d, op_d, a_ack_d, b_ack_d, busy_d;

  mem_arb_rr u_rr (
    .req        ({b_req, a_req}),
    .last_grant (last_grant),
    .gnt        (gnt),
    .gnt_valid  (gnt_valid)
  );

  // Outputs are computed for the state being entered, then registered.
  always_comb begin
    state_next = state;
    sel_d      = 1'b0;
    op_d       = 1'b0;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          state_next = ACCESS;
          sel_d      = 1'b1;
          op_d       = (gnt == REQ_B) ? b_we : a_we;
        end
      end
      ACCESS: begin
        if (VERIFY_EN && we_q) begin
          state_next = VERIFY;
          sel_d      = 1'b1;
        end else begin
          state_next = RESP;
          a_ack_d    = (gnt_q == REQ_A);
          b_ack_d    = (gnt_q == REQ_B);
        end
      end
      VERIFY: begin
        state_next = RESP;
        a_ack_d    = (gnt_q == REQ_A);
        b_ack_d    = (gnt_q == REQ_B);
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_d = (state_next != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= REQ_B;
      gnt_q      <= REQ_A;
      we_q       <= 1'b0;
      mem_select <= 1'b0;
      mem_op     <= 1'b0;
      mem_adr    <= '0;
      mem_i      <= '0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      mem_select <= sel_d;
      mem_op     <= op_d;
      a_ack      <= a_ack_d;
      b_ack      <= b_ack_d;
      busy       <= busy_d;
      // mem_adr/mem_i double as the command latch and hold between transactions.
      if (state == IDLE && gnt_valid) begin
        gnt_q      <= gnt;
        last_grant <= gnt;
        we_q       <= (gnt == REQ_B) ? b_we    : a_we;
        mem_adr    <= (gnt == REQ_B) ? b_adr   : a_adr;
        mem_i      <= (gnt == REQ_B) ? b_wdata : a_wdata;
      end
      if (state == ACCESS && !we_q) begin
        if (gnt_q == REQ_B) b_rdata <= mem_o;
        else                a_rdata <= mem_o;
      end
    end
  end

`ifdef MEM_ARB_VERIFY_EN
  // Read-back result lands in RESP, coincident with the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= (state == VERIFY) && (mem_o != mem_i);
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a behavioural mem_system
module tb_mem_arbiter;

`ifdef MEM_ARB_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  localparam int WR_LAT = VER ? 4 : 3;
  localparam int RD_LAT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [2:0] a_adr = '0, b_adr = '0;
  logic [7:0] a_wdata = '0, b_wdata = '0;
  logic       a_ack, b_ack, mem_op, mem_select, busy, err;
  logic [7:0] a_rdata, b_rdata, mem_i, mem_o;
  logic [2:0] mem_adr;

  logic [7:0] mem [8];
  bit         force_en = 1'b0;
  logic [7:0] force_val = 8'h00;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit         who;
    bit         we;
    logic [2:0] adr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit         who;
    bit         we;
    logic [7:0] rdata;
    bit         err;
    int         sel;
  } exp_t;

  vec_t vecs[16];
  exp_t sbq[$];
  exp_t mon_e;
  int   sel_cnt = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_req      (a_req),
    .a_we       (a_we),
    .a_adr      (a_adr),
    .a_wdata    (a_wdata),
    .a_ack      (a_ack),
    .a_rdata    (a_rdata),
    .b_req      (b_req),
    .b_we       (b_we),
    .b_adr      (b_adr),
    .b_wdata    (b_wdata),
    .b_ack      (b_ack),
    .b_rdata    (b_rdata),
    .mem_op     (mem_op),
    .mem_select (mem_select),
    .mem_adr    (mem_adr),
    .mem_i      (mem_i),
    .mem_o      (mem_o),
    .busy       (busy),
    .err        (err)
  );

  // mem_system model; 0xEE stands in for the undriven bus.
  always @(posedge clk) if (mem_select && mem_op) mem[mem_adr] <= mem_i;
  assign mem_o = (mem_select && !mem_op) ? (force_en ? force_val : mem[mem_adr]) : 8'hEE;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      sel_cnt = 0;
      prev_a  = 1'b0;
      prev_b  = 1'b0;
    end else begin
      if (mem_select) sel_cnt++;
      if (a_ack || b_ack) begin
        chk("ack_onehot", int'(a_ack & b_ack), 0);
        chk("ack_pulse", int'((prev_a & a_ack) | (prev_b & b_ack)), 0);
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ack: a_ack=%0b b_ack=%0b with empty scoreboard at %0t", a_ack, b_ack, $time);
        end else begin
          mon_e = sbq.pop_front();
          chk("ack_who", int'(b_ack), int'(mon_e.who));
          if (!mon_e.we) chk("rdata", int'(mon_e.who ? b_rdata : a_rdata), int'(mon_e.rdata));
          chk("err", int'(err), int'(mon_e.err));
          chk("select_cycles", sel_cnt, mon_e.sel);
        end
        sel_cnt = 0;
      end else begin
        chk("err_idle", int'(err), 0);
      end
      prev_a = a_ack;
      prev_b = b_ack;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the ack edge with req dropped.
  task automatic run_txn(input bit who, input bit we, input logic [2:0] adr,
                         input logic [7:0] wdata, input logic [7:0] exp_rd, input bit exp_err);
    int   lat;
    bit   seen;
    exp_t e;
    e.who = who; e.we = we; e.rdata = exp_rd; e.err = exp_err;
    e.sel = (we && VER) ? 2 : 1;
    sbq.push_back(e);
    if (!who) begin a_we = we; a_adr = adr; a_wdata = wdata; a_req = 1'b1; end
    else      begin b_we = we; b_adr = adr; b_wdata = wdata; b_req = 1'b1; end
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 12) begin
      @(negedge clk);
      lat++;
      if ((!who && a_ack) || (who && b_ack)) seen = 1'b1;
    end
    chk("latency", seen ? lat : -1, we ? WR_LAT : RD_LAT);
    @(posedge clk);
    #1;
    if (!who) a_req = 1'b0;
    else      b_req = 1'b0;
  endtask

  // Both requesters hold reads (A adr1, B adr2) for n grants; A is expected first.
  task automatic contend(input int n);
    int   acks, guard;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.who = k[0]; e.we = 1'b0; e.err = 1'b0; e.sel = 1;
      e.rdata = k[0] ? 8'h20 : 8'h53;
      sbq.push_back(e);
    end
    a_we = 1'b0; a_adr = 3'd1; b_we = 1'b0; b_adr = 3'd2;
    a_req = 1'b1; b_req = 1'b1;
    acks = 0;
    guard = 0;
    while (acks < n && guard < 40) begin
      @(negedge clk);
      guard++;
      if (a_ack || b_ack) acks++;
    end
    chk("contention_acks", acks, n);
    @(posedge clk);
    #1;
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] msg [8];
    msg = '{8'h4C, 8'h53, 8'h20, 8'h53, 8'h57, 8'h4B, 8'h20, 8'h21};
    for (int k = 0; k < 8; k++) begin
      vecs[k]     = '{who: 1'b1, we: 1'b1, adr: 3'(k), wdata: msg[k], exp_rdata: 8'h00};
      vecs[k + 8] = '{who: 1'b1, we: 1'b0, adr: 3'(k), wdata: 8'h00, exp_rdata: msg[k]};
    end

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_select", int'(mem_select), 0);
    chk("rst_op", int'(mem_op), 0);
    chk("rst_acks", int'({a_ack, b_ack}), 0);
    chk("rst_rdata", int'({a_rdata, b_rdata}), 0);
    chk("rst_adr_i", int'({mem_adr, mem_i}), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_txn(1'b0, 1'b1, 3'd3, 8'h53, 8'h00, 1'b0);
    run_txn(1'b0, 1'b0, 3'd3, 8'h00, 8'h53, 1'b0);

    for (int k = 0; k < 16; k++)
      run_txn(vecs[k].who, vecs[k].we, vecs[k].adr, vecs[k].wdata, vecs[k].exp_rdata, 1'b0);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    contend(4);

    run_txn(1'b0, 1'b0, 3'd0, 8'h00, 8'h4C, 1'b0);
    run_txn(1'b1, 1'b1, 3'd0, 8'hFF, 8'h00, 1'b0);
    chk("a_rdata_hold", int'(a_rdata), 8'h4C);
    run_txn(1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b0);

    a_we = 1'b1; a_adr = 3'd5; a_wdata = 8'hAA; a_req = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_in_access", int'(mem_select), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_select", int'(mem_select), 0);
    chk("abort_ack", int'(a_ack), 0);
    chk("abort_busy", int'(busy), 0);
    a_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    contend(2);

`ifdef MEM_ARB_VERIFY_EN
    force_en  = 1'b1;
    force_val = 8'h20;
    run_txn(1'b0, 1'b1, 3'd7, 8'h21, 8'h00, 1'b1);
    force_en  = 1'b0;
    run_txn(1'b0, 1'b1, 3'd7, 8'h21, 8'h00, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
